// File: rtl/vga_pkg.sv
// Shared constants, FSM encoding and colour helper for the pixel upscaler.
// Imported by the line buffer and the pixel_upscaler_4x top.
package vga_pkg;

    localparam int SRC_W    = 160;
    localparam int SRC_H    = 120;
    localparam int SCALE    = 4;
    localparam int H_ACTIVE = SRC_W * SCALE;
    localparam int V_ACTIVE = SRC_H * SCALE;
    localparam int SCALE_LG = $clog2(SCALE);
    localparam int XW       = $clog2(SRC_W);

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // RGB565 -> RGB888 by replicating the top bits into the new LSBs
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] d);
        return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
    endfunction

endpackage

// File: rtl/pixel_upscaler_4x_if.sv
// FWFT FIFO read handshake between the camera FIFO and the upscaler.
// Signals: empty_fifo (head valid when low), din (RGB565 head), rd_en (pop).
interface pixel_upscaler_4x_if;

    logic        empty_fifo;
    logic [15:0] din;
    logic        rd_en;

    modport master (output empty_fifo, output din, input rd_en);
    modport slave  (input empty_fifo, input din, output rd_en);

endinterface

// File: rtl/line_buffer_dp.sv
// Two-bank line buffer, 2 x SRC_W x 16, simple dual port, registered read.
// Ports: clk, write (i_we/i_wbank/i_waddr/i_wdata), read (i_re/i_rbank/i_raddr/o_rdata).
module line_buffer_dp
    import vga_pkg::*;
(
    input  logic          clk,
    input  logic          i_we,
    input  logic          i_wbank,
    input  logic [XW-1:0] i_waddr,
    input  logic [15:0]   i_wdata,
    input  logic          i_re,
    input  logic          i_rbank,
    input  logic [XW-1:0] i_raddr,
    output logic [15:0]   o_rdata
);

    logic [15:0] r_mem [2][SRC_W];
    logic [15:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wbank][i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_rbank][i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/pixel_upscaler_4x.sv
// Replicates each camera pixel SCALE x SCALE onto the VGA raster, RGB565 -> RGB888.
// Ports: clk_out, rst_n, fifo (FIFO handshake), pixel_x/y, video_on, hs_in, vs_in, vga_out_*, underflow.
module pixel_upscaler_4x
    import vga_pkg::*;
(
    input  logic                      clk_out,
    input  logic                      rst_n,
    pixel_upscaler_4x_if.slave        fifo,
    input  logic [11:0]               pixel_x,
    input  logic [11:0]               pixel_y,
    input  logic                      video_on,
    input  logic                      hs_in,
    input  logic                      vs_in,
    output logic [7:0]                vga_out_r,
    output logic [7:0]                vga_out_g,
    output logic [7:0]                vga_out_b,
    output logic                      vga_out_hs,
    output logic                      vga_out_vs,
    output logic                      underflow
);

    state_t        r_state;
    logic [1:0]    r_full;
    logic          r_fill_bank;
    logic          r_disp_bank;
    logic [XW-1:0] r_wr_x;
    logic          r_underflow;
    logic          r_black;
    logic [1:0]    r_hs;
    logic [1:0]    r_vs;
    logic [23:0]   r_rgb;

    logic          w_run;
    logic          w_rd_en;
    logic          w_wr_last;
    logic          w_release;
    logic          w_black;
    logic          w_re;
    logic [XW-1:0] w_raddr;
    logic [15:0]   w_rdata;

    assign w_run     = (r_state == ST_RUN);
    assign w_rd_en   = w_run && !fifo.empty_fifo && !r_full[r_fill_bank];
    assign w_wr_last = w_rd_en && (r_wr_x == XW'(SRC_W - 1));
    assign w_release = w_run
                    && (pixel_x == 12'(H_ACTIVE - 1))
                    && (pixel_y < 12'(V_ACTIVE))
                    && (pixel_y[SCALE_LG-1:0] == SCALE_LG'(SCALE - 1));
    assign w_raddr   = pixel_x[SCALE_LG +: XW];
    assign w_re      = w_run && video_on;
    // Black decision travels with the RAM read so it lines up with the data
    assign w_black   = !video_on || !w_run || !r_full[r_disp_bank];

    assign fifo.rd_en = w_rd_en;

    line_buffer_dp u_lbuf (
        .clk     (clk_out),
        .i_we    (w_rd_en),
        .i_wbank (r_fill_bank),
        .i_waddr (r_wr_x),
        .i_wdata (fifo.din),
        .i_re    (w_re),
        .i_rbank (r_disp_bank),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_WAIT;
            r_full      <= '0;
            r_fill_bank <= 1'b0;
            r_disp_bank <= 1'b0;
            r_wr_x      <= '0;
            r_underflow <= 1'b0;
            r_black     <= 1'b1;
            r_hs        <= '1;
            r_vs        <= '1;
            r_rgb       <= '0;
        end else begin
            unique case (r_state)
                ST_WAIT: begin
                    if (pixel_x == 12'd0 && pixel_y == 12'(V_ACTIVE)) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: r_state <= ST_RUN;
            endcase

            if (w_rd_en) begin
                r_wr_x <= w_wr_last ? '0 : r_wr_x + 1'b1;
            end
            if (w_wr_last) begin
                r_full[r_fill_bank] <= 1'b1;
                r_fill_bank         <= ~r_fill_bank;
            end
            // Placed after the fill update so a release on the same bank wins
            if (w_release) begin
                if (r_full[r_disp_bank]) begin
                    r_full[r_disp_bank] <= 1'b0;
                    r_disp_bank         <= ~r_disp_bank;
                end else begin
                    r_underflow <= 1'b1;
                end
            end

            r_black <= w_black;
            r_hs    <= {r_hs[0], hs_in};
            r_vs    <= {r_vs[0], vs_in};
            r_rgb   <= r_black ? 24'h0 : rgb565_to_888(w_rdata);
        end
    end

    assign vga_out_r  = r_rgb[23:16];
    assign vga_out_g  = r_rgb[15:8];
    assign vga_out_b  = r_rgb[7:0];
    assign vga_out_hs = r_hs[1];
    assign vga_out_vs = r_vs[1];
    assign underflow  = r_underflow;

endmodule

// File: tb/tb_pixel_upscaler_4x.sv
// Self-checking bench for pixel_upscaler_4x: line-count model plus literal probes.
// Drives a sparse raster (chosen rows only) to stay within a small cycle budget.
module tb_pixel_upscaler_4x;
    import vga_pkg::*;

    localparam int H_ROW = 660;

    logic        clk_out = 1'b0;
    logic        rst_n   = 1'b1;
    logic [11:0] pixel_x = '0;
    logic [11:0] pixel_y = '0;
    logic        video_on = 1'b0;
    logic        hs_in = 1'b1;
    logic        vs_in = 1'b1;
    logic [7:0]  vga_out_r, vga_out_g, vga_out_b;
    logic        vga_out_hs, vga_out_vs, underflow;

    pixel_upscaler_4x_if fif ();

    pixel_upscaler_4x dut (
        .clk_out    (clk_out),
        .rst_n      (rst_n),
        .fifo       (fif),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .video_on   (video_on),
        .hs_in      (hs_in),
        .vs_in      (vs_in),
        .vga_out_r  (vga_out_r),
        .vga_out_g  (vga_out_g),
        .vga_out_b  (vga_out_b),
        .vga_out_hs (vga_out_hs),
        .vga_out_vs (vga_out_vs),
        .underflow  (underflow)
    );

    always #20 clk_out = ~clk_out;

    typedef struct {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    int          dut_pops = 0;
    int          mark;
    logic [15:0] fq[$];
    bit          hold_empty = 0;
    bit          lit_en = 0;
    logic [23:0] cap_rgb;
    logic        cap_uf;

    // Model: counts of lines popped vs lines released, no bank bookkeeping
    bit          m_run;
    logic [15:0] m_words[$];
    int          m_disp;
    bit          m_uf;
    exp_t        s1, s2;

    function automatic logic [23:0] expand(input logic [15:0] d);
        int r, g, b;
        r = int'(d[15:11]);
        g = int'(d[10:5]);
        b = int'(d[4:0]);
        r = r * 8 + r / 4;
        g = g * 4 + g / 16;
        b = b * 8 + b / 4;
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    function automatic logic [15:0] pat(input int n, input int k);
        return 16'(k * 16'h0123 + n * 16'h3C5A + 16'h0101);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (y=%0d x=%0d)",
                     nm, act, exp, pixel_y, pixel_x);
        end
    endtask

    task automatic m_reset();
        m_run = 0;
        m_words.delete();
        m_disp = 0;
        m_uf = 0;
        s1 = '{rgb: 24'h0, hs: 1'b1, vs: 1'b1};
        s2 = s1;
    endtask

    task automatic cyc(input int x, input int y);
        bit von, hs, vs, pop, full_disp;
        int filled;
        von = (x < H_ACTIVE) && (y < V_ACTIVE);
        hs  = !(x >= 648 && x < 656);
        vs  = !(y == 490 || y == 491);
        pixel_x  = 12'(x);
        pixel_y  = 12'(y);
        video_on = von;
        hs_in    = hs;
        vs_in    = vs;
        fif.empty_fifo = hold_empty || (fq.size() == 0);
        fif.din = (fq.size() != 0) ? fq[0] : 16'h0;
        @(negedge clk_out);
        filled    = m_words.size() / SRC_W;
        full_disp = filled > m_disp;
        pop = rst_n && m_run && !fif.empty_fifo && (filled - m_disp) < 2;
        cap_rgb = {vga_out_r, vga_out_g, vga_out_b};
        cap_uf  = underflow;
        chk("rgb", 32'(cap_rgb), 32'(s2.rgb));
        chk("hs", 32'(vga_out_hs), 32'(s2.hs));
        chk("vs", 32'(vga_out_vs), 32'(s2.vs));
        chk("underflow", 32'(underflow), 32'(m_uf));
        chk("rd_en", 32'(fif.rd_en), 32'(pop));
        if (fif.rd_en) dut_pops++;
        if (!rst_n) begin
            m_reset();
        end else begin
            s2 = s1;
            s1.hs = hs;
            s1.vs = vs;
            s1.rgb = (m_run && von && full_disp)
                   ? expand(m_words[m_disp * SRC_W + x / SCALE]) : 24'h0;
            if (m_run && x == H_ACTIVE - 1 && y < V_ACTIVE && (y % SCALE) == SCALE - 1) begin
                if (full_disp) m_disp++;
                else m_uf = 1;
            end
            if (pop) m_words.push_back(fq.pop_front());
            if (!m_run && x == 0 && y == V_ACTIVE) m_run = 1;
        end
        @(posedge clk_out);
        #1;
    endtask

    task automatic run_x(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) begin
            cyc(x, y);
            if (lit_en && x == 102) begin
                if (y == 1)  chk("lit_F800", 32'(cap_rgb), 32'h00FF0000);
                if (y == 5)  chk("lit_07E0", 32'(cap_rgb), 32'h0000FF00);
                if (y == 9)  chk("lit_8410", 32'(cap_rgb), 32'h00848284);
            end
        end
    endtask

    task automatic row(input int y);
        run_x(y, 0, H_ROW - 1);
    endtask

    task automatic do_reset(input int y, input int x0, input int n);
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("rst_rgb", 32'({vga_out_r, vga_out_g, vga_out_b}), 32'h0);
        chk("rst_hs", 32'(vga_out_hs), 32'h1);
        chk("rst_vs", 32'(vga_out_vs), 32'h1);
        chk("rst_rd_en", 32'(fif.rd_en), 32'h0);
        chk("rst_uf", 32'(underflow), 32'h0);
        run_x(y, x0, x0 + n - 1);
        rst_n = 1'b1;
    endtask

    initial begin
        m_reset();
        fif.empty_fifo = 1'b1;
        fif.din = '0;
        for (int k = 0; k < SRC_W; k++) fq.push_back(16'hF800);
        for (int k = 0; k < SRC_W; k++) fq.push_back(16'h07E0);
        for (int k = 0; k < SRC_W; k++) fq.push_back(16'h8410);
        for (int n = 3; n < 6; n++)
            for (int k = 0; k < SRC_W; k++) fq.push_back(pat(n, k));

        #2;
        do_reset(470, 0, 4);

        row(478);
        row(479);
        chk("pops_wait", 32'(dut_pops), 32'd0);
        row(V_ACTIVE);
        row(V_ACTIVE + 1);
        chk("pops_start", 32'(dut_pops), 32'd320);

        lit_en = 1;
        for (int y = 0; y < 28; y++) row(y);
        lit_en = 0;
        chk("uf_late", 32'(underflow), 32'h1);

        for (int n = 10; n < 16; n++)
            for (int k = 0; k < SRC_W; k++) fq.push_back(pat(n, k));
        row(199);
        run_x(200, 0, 299);
        do_reset(200, 300, 4);
        run_x(200, 304, H_ROW - 1);
        mark = dut_pops;
        for (int y = 201; y < 204; y++) row(y);
        chk("pops_after_rst", 32'(dut_pops - mark), 32'd0);
        chk("uf_after_rst", 32'(underflow), 32'h0);
        row(V_ACTIVE);
        chk("pops_refill", 32'(dut_pops - mark), 32'd320);
        for (int y = 0; y < 8; y++) row(y);

        do_reset(300, 0, 3);
        hold_empty = 1;
        run_x(300, 3, H_ROW - 1);
        row(V_ACTIVE);
        for (int y = 0; y < 3; y++) row(y);
        run_x(3, 0, H_ACTIVE - 1);
        chk("uf_before", 32'(cap_uf), 32'h0);
        run_x(3, H_ACTIVE, H_ACTIVE);
        chk("uf_set", 32'(cap_uf), 32'h1);
        run_x(3, H_ACTIVE + 1, H_ROW - 1);
        row(4);
        chk("uf_sticky", 32'(underflow), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
